// File: rtl/vad_gate_ctrl.sv
// VAD-driven capture gate: confirms speech onset, rewinds the pre-trigger buffer,
// streams the backlog while speech lasts and drains it once the hangover expires.
module vad_gate_ctrl #(
   parameter int BUFFER_SIZE         = 24000,
   parameter int PRE_TRIGGER_SAMPLES = 3200,
   parameter int MIN_ON_SAMPLES      = 480,
   parameter int HANGOVER_SAMPLES    = 4800,
   parameter int CNT_WIDTH           = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic        vad_active,
   input  logic        out_ready,
   input  logic [15:0] buf_data_out,
   input  logic        buf_data_valid,
   output logic        pre_trig_rewind,
   output logic        rd_en,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        gate_open,
   output logic        segment_start,
   output logic        segment_end,
   output logic        overflow
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CONFIRM  = 3'd1;
   localparam logic [2:0] ST_REWIND   = 3'd2;
   localparam logic [2:0] ST_STREAM   = 3'd3;
   localparam logic [2:0] ST_HANGOVER = 3'd4;
   localparam logic [2:0] ST_DRAIN    = 3'd5;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] BACKLOG_MAX = CNT_WIDTH'(BUFFER_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] PRE_LOAD    = CNT_WIDTH'(PRE_TRIGGER_SAMPLES);
   localparam logic [CNT_WIDTH-1:0] ON_TARGET   = CNT_WIDTH'(MIN_ON_SAMPLES);
   localparam logic [CNT_WIDTH-1:0] OFF_TARGET  = CNT_WIDTH'(HANGOVER_SAMPLES);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   logic [2:0]           state_r, state_s;
   logic [CNT_WIDTH-1:0] on_cnt_r, on_cnt_s;
   logic [CNT_WIDTH-1:0] off_cnt_r, off_cnt_s;
   logic [CNT_WIDTH-1:0] backlog_r, backlog_s;
   logic                 overflow_r, overflow_s;
   logic                 rd_en_r, rd_en_s;
   logic                 pend_r, pend_s;
   logic                 pre_trig_rewind_r, segment_start_r, segment_end_r, gate_open_r;
   logic                 out_valid_r;
   logic [15:0]          out_data_r;
   logic                 sample_on_s, sample_off_s, rd_state_s, inc_s, dec_s;
   logic                 drain_done_s, gate_next_s, fwd_s;

   assign sample_on_s  = sample_valid & vad_active;
   assign sample_off_s = sample_valid & ~vad_active;
   assign rd_state_s   = (state_r == ST_STREAM) | (state_r == ST_HANGOVER) | (state_r == ST_DRAIN);
   assign inc_s        = sample_valid & ((state_r == ST_REWIND) | (state_r == ST_STREAM) |
                                         (state_r == ST_HANGOVER));
   assign dec_s        = rd_en_r & rd_state_s;
   // Segment ends only once the last issued read has come back and been forwarded.
   assign drain_done_s = (state_r == ST_DRAIN) & (backlog_r == CNT_ZERO) & ~rd_en_r & ~pend_r;
   assign gate_next_s  = (state_s == ST_REWIND) | (state_s == ST_STREAM) |
                         (state_s == ST_HANGOVER) | (state_s == ST_DRAIN);
   assign rd_en_s      = rd_state_s & (backlog_r != CNT_ZERO) & out_ready & ~rd_en_r &
                         ~pre_trig_rewind_r;
   assign fwd_s        = buf_data_valid & gate_open_r;
   assign pend_s       = rd_en_r ? 1'b1 : (buf_data_valid ? 1'b0 : pend_r);

   // Next-state and on/off counter logic.
   always_comb begin
      state_s   = state_r;
      on_cnt_s  = on_cnt_r;
      off_cnt_s = off_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (sample_on_s) begin
               state_s  = ST_CONFIRM;
               on_cnt_s = CNT_ONE;
            end else begin
               on_cnt_s  = CNT_ZERO;
               off_cnt_s = CNT_ZERO;
            end
         end
         ST_CONFIRM: begin
            if (on_cnt_r >= ON_TARGET) begin
               state_s  = ST_REWIND;
               on_cnt_s = CNT_ZERO;
            end else if (sample_on_s) begin
               on_cnt_s = sat_inc(on_cnt_r);
            end else if (sample_off_s) begin
               state_s  = ST_IDLE;
               on_cnt_s = CNT_ZERO;
            end else begin
               state_s = ST_CONFIRM;
            end
         end
         ST_REWIND: begin
            state_s   = ST_STREAM;
            off_cnt_s = CNT_ZERO;
         end
         ST_STREAM: begin
            if (sample_off_s) begin
               state_s   = ST_HANGOVER;
               off_cnt_s = CNT_ONE;
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_HANGOVER: begin
            if (off_cnt_r >= OFF_TARGET) begin
               state_s   = ST_DRAIN;
               off_cnt_s = CNT_ZERO;
            end else if (sample_on_s) begin
               state_s   = ST_STREAM;
               off_cnt_s = CNT_ZERO;
            end else if (sample_valid) begin
               off_cnt_s = sat_inc(off_cnt_r);
            end else begin
               state_s = ST_HANGOVER;
            end
         end
         ST_DRAIN: begin
            if (drain_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            on_cnt_s  = CNT_ZERO;
            off_cnt_s = CNT_ZERO;
         end
      endcase
   end

   // Backlog accounting; a write that lands on a full backlog is dropped and flagged.
   always_comb begin
      backlog_s  = backlog_r;
      overflow_s = overflow_r;
      if ((state_r == ST_CONFIRM) && (state_s == ST_REWIND)) begin
         backlog_s = PRE_LOAD;
      end else if ((state_r == ST_IDLE) || (state_r == ST_CONFIRM)) begin
         backlog_s = CNT_ZERO;
      end else if (inc_s && !dec_s) begin
         if (backlog_r >= BACKLOG_MAX) begin
            overflow_s = 1'b1;
         end else begin
            backlog_s = backlog_r + CNT_ONE;
         end
      end else if (dec_s && !inc_s) begin
         if (backlog_r != CNT_ZERO) begin
            backlog_s = backlog_r - CNT_ONE;
         end else begin
            backlog_s = CNT_ZERO;
         end
      end else begin
         backlog_s = backlog_r;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= ST_IDLE;
         on_cnt_r          <= CNT_ZERO;
         off_cnt_r         <= CNT_ZERO;
         backlog_r         <= CNT_ZERO;
         overflow_r        <= 1'b0;
         rd_en_r           <= 1'b0;
         pend_r            <= 1'b0;
         pre_trig_rewind_r <= 1'b0;
         segment_start_r   <= 1'b0;
         segment_end_r     <= 1'b0;
         gate_open_r       <= 1'b0;
         out_valid_r       <= 1'b0;
         out_data_r        <= 16'd0;
      end else begin
         state_r           <= state_s;
         on_cnt_r          <= on_cnt_s;
         off_cnt_r         <= off_cnt_s;
         backlog_r         <= backlog_s;
         overflow_r        <= overflow_s;
         rd_en_r           <= rd_en_s;
         pend_r            <= pend_s;
         pre_trig_rewind_r <= (state_s == ST_REWIND);
         segment_start_r   <= (state_s == ST_REWIND);
         segment_end_r     <= drain_done_s;
         gate_open_r       <= gate_next_s;
         out_valid_r       <= fwd_s;
         out_data_r        <= fwd_s ? buf_data_out : out_data_r;
      end
   end

   assign pre_trig_rewind = pre_trig_rewind_r;
   assign rd_en           = rd_en_r;
   assign out_data        = out_data_r;
   assign out_valid       = out_valid_r;
   assign gate_open       = gate_open_r;
   assign segment_start   = segment_start_r;
   assign segment_end     = segment_end_r;
   assign overflow        = overflow_r;

endmodule

// File: doc/vad_gate_ctrl.md
VAD_GATE_CTRL -- requirements
Module: vad_gate_ctrl

Interface
REQ-001 Parameters SHALL be name, default, meaning:
- BUFFER_SIZE, 24000, depth of the sequenced circular buffer.
- PRE_TRIGGER_SAMPLES, 3200, rewind distance issued at speech onset.
- MIN_ON_SAMPLES, 480, consecutive VAD-high samples needed to open the gate.
- HANGOVER_SAMPLES, 4800, VAD-low samples tolerated before closing.
- CNT_WIDTH, 15, width of all internal counters.

REQ-002 Ports SHALL be name, direction, width, meaning:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- sample_valid, in, 1, write strobe seen by the buffer.
- vad_active, in, 1, raw VAD decision, sampled only on sample_valid.
- out_ready, in, 1, downstream can take one sample.
- buf_data_out, in, 16, buffer read data.
- buf_data_valid, in, 1, buffer read data valid.
- pre_trig_rewind, out, 1, one-cycle rewind pulse to the buffer.
- rd_en, out, 1, buffer read strobe.
- out_data, out, 16, gated sample.
- out_valid, out, 1, one-cycle gated-sample strobe.
- gate_open, out, 1, high in REWIND, STREAM, HANGOVER and DRAIN.
- segment_start, out, 1, one-cycle pulse at the rewind.
- segment_end, out, 1, one-cycle pulse when the drain completes.
- overflow, out, 1, sticky flag set when the backlog saturates.

Function
REQ-003 The FSM SHALL have the states IDLE, CONFIRM, REWIND, STREAM, HANGOVER and DRAIN, with exactly one state active at a time.

REQ-004 IDLE SHALL move to CONFIRM, with on_cnt=1, on sample_valid while vad_active=1.

REQ-005 CONFIRM SHALL behave as follows:
- Increment on_cnt on each sample_valid with vad_active=1.
- Return to IDLE on sample_valid with vad_active=0.
- Enter REWIND in the cycle after on_cnt reaches MIN_ON_SAMPLES.

REQ-006 REWIND SHALL last exactly 1 cycle and SHALL then go to STREAM:
- Assert pre_trig_rewind and segment_start.
- Load backlog with PRE_TRIGGER_SAMPLES.

REQ-007 In STREAM and HANGOVER, backlog SHALL count as follows:
- +1 per sample_valid.
- -1 per rd_en.
- Unchanged when both occur in the same cycle.

REQ-008 rd_en SHALL assert for 1 cycle only when all of these hold:
- State is STREAM, HANGOVER or DRAIN.
- backlog>0 and out_ready=1.
- No read is in flight, i.e. rd_en was not high in the previous cycle.
- pre_trig_rewind is low.

REQ-009 out_data and out_valid SHALL be registered from buf_data_out and buf_data_valid, giving 1 cycle latency from buf_data_valid; buf_data_valid outside gate_open SHALL be ignored.

REQ-010 STREAM SHALL enter HANGOVER with off_cnt=1 on sample_valid while vad_active=0.

REQ-011 HANGOVER SHALL behave as follows:
- Return to STREAM with off_cnt cleared on sample_valid while vad_active=1.
- Otherwise increment off_cnt on each sample_valid.
- Enter DRAIN when off_cnt reaches HANGOVER_SAMPLES.

REQ-012 DRAIN SHALL stop counting sample_valid, decrement backlog on rd_en only, and, after backlog reaches 0 and the last read data has been forwarded, pulse segment_end for 1 cycle and return to IDLE.

REQ-013 backlog SHALL saturate at BUFFER_SIZE-1; the increment that would exceed it SHALL be dropped and SHALL set overflow, which clears only on reset.

REQ-014 vad_active SHALL be ignored when sample_valid=0, and vad_active in DRAIN SHALL NOT reopen the gate; a new segment starts from IDLE only.

REQ-015 All counters SHALL be CNT_WIDTH-bit unsigned and SHALL NOT wrap.

REQ-016 Reset SHALL force the following:
- FSM to IDLE.
- on_cnt, off_cnt and backlog to 0.
- pre_trig_rewind, rd_en, out_valid, segment_start, segment_end, gate_open and overflow to 0.
- out_data to 16'd0.

REQ-017 Reset asserted mid-segment SHALL abandon the segment immediately with no segment_end pulse, and the first cycle after release SHALL behave as IDLE.

Verification
Bench parameters are BUFFER_SIZE=32, PRE_TRIGGER_SAMPLES=8, MIN_ON_SAMPLES=3, HANGOVER_SAMPLES=4, with sample_valid every 4 cycles.

REQ-018 Onset: 3 VAD-high samples -> one pre_trig_rewind plus segment_start pulse; backlog=8; gate_open=1.

REQ-019 Glitch reject: VAD high for 2 samples then low -> return to IDLE; no rewind; rd_en never asserted.

REQ-020 Stream and drain with out_ready=1 throughout and VAD high for 10 samples -> rd_en pulses ≥2 cycles apart; each out_valid arrives 2 cycles after its rd_en; after 4 low samples, DRAIN empties the backlog; segment_end pulses once; total out_valid pulses = 8 + samples written from REWIND to DRAIN entry.

REQ-021 Hangover bridge: VAD low for 3 samples then high -> stays in STREAM; no segment_end; off_cnt=0.

REQ-022 Backpressure: out_ready=0 in STREAM for 100 cycles -> backlog saturates at 31; overflow=1; no rd_en.

REQ-023 Mid-segment reset: rst_n low during HANGOVER -> all outputs 0 asynchronously; no segment_end; a new 3-sample onset after release produces a normal rewind.
